// File: rtl/t9990_blit_pixrd.sv
// Blitter pixel reader: maps (X,Y,mode) to a VRAM word, fetches or reuses a one-word cache, extracts the pixel.
// Latency: hit -> PIX_VALID two cycles after REQ; miss -> PIX_VALID one cycle after MEM_ACK.
// Backpressure: READY is high only in IDLE; REQ while busy is dropped; MEM_REQ is held until MEM_ACK.
module t9990_blit_pixrd (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic [10:0] x_i,
  input  logic [11:0] y_i,
  input  logic [1:0]  clrm_i,
  input  logic [1:0]  ximm_i,
  input  logic        p1_i,
  input  logic        invalidate_i,
  output logic        ready_o,
  output logic        mem_req_o,
  output logic [18:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        pix_valid_o,
  output logic [15:0] pix_o
);

  // Colour mode and image width encodings.
  localparam logic [1:0] CLRM_2BPP  = 2'd0;
  localparam logic [1:0] CLRM_4BPP  = 2'd1;
  localparam logic [1:0] CLRM_8BPP  = 2'd2;
  localparam logic [1:0] CLRM_16BPP = 2'd3;

  localparam logic [1:0] XIMM_256   = 2'd0;
  localparam logic [1:0] XIMM_512   = 2'd1;
  localparam logic [1:0] XIMM_1024  = 2'd2;
  localparam logic [1:0] XIMM_2048  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FETCH = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t      state_q, state_d;

  // Request parameters captured when the request is accepted.
  logic [10:0] x_q;
  logic [11:0] y_q;
  logic [1:0]  clrm_q;
  logic [1:0]  ximm_q;
  logic        p1_q;

  logic [18:0] addr_q;
  logic        valid_q;
  logic [18:0] tag_q;
  logic [31:0] word_q;
  logic [15:0] pix_q;

  logic        accept;
  logic        hit;
  logic        load_pix;

  logic [10:0] x_mask;
  logic [3:0]  row_shift;
  logic [18:0] row_base;
  logic [18:0] x_byte;
  logic [18:0] byte_addr;
  logic [18:0] norm_addr;
  logic [18:0] p1_addr;
  logic [18:0] calc_addr;

  logic [31:0] src_word;
  logic [7:0]  sel_byte;
  logic [15:0] pix_ext;

  assign mem_addr_o = addr_q;
  assign pix_o      = pix_q;
  assign accept     = (state_q == S_IDLE) && req_i;

  // Word address: row stride is width*bpp/8 bytes, so the row offset is a left shift
  // by log2(width)+log2(bpp)-3; X beyond the image width wraps into the row.
  always_comb begin
    x_mask = x_q;
    case (ximm_q)
      XIMM_256:  x_mask = {3'd0, x_q[7:0]};
      XIMM_512:  x_mask = {2'd0, x_q[8:0]};
      XIMM_1024: x_mask = {1'd0, x_q[9:0]};
      XIMM_2048: x_mask = x_q;
      default:   x_mask = x_q;
    endcase
    row_shift = 4'd6 + {2'd0, ximm_q} + {2'd0, clrm_q};
    row_base  = {7'd0, y_q} << row_shift;
    x_byte    = ({8'd0, x_mask} << clrm_q) >> 2;
    byte_addr = row_base + x_byte;
    norm_addr = byte_addr & ~19'd3;
    p1_addr   = {x_q[9] ^ y_q[11], y_q[10:0], x_q[7:3], 2'b00};
    calc_addr = p1_q ? p1_addr : norm_addr;
  end

  assign hit = valid_q && (tag_q == calc_addr);

  // Pixel extraction from the word arriving from memory (miss) or from the cache (hit).
  always_comb begin
    src_word = (state_q == S_FETCH) ? mem_rdata_i : word_q;
    sel_byte = 8'd0;
    pix_ext  = 16'd0;
    if (p1_q || (clrm_q == CLRM_4BPP)) begin
      sel_byte = src_word[{x_q[2:1], 3'b000} +: 8];
      pix_ext  = {12'd0, x_q[0] ? sel_byte[3:0] : sel_byte[7:4]};
    end else begin
      case (clrm_q)
        CLRM_2BPP: begin
          // Leftmost pixel sits in the top bits of the byte.
          sel_byte = src_word[{x_q[3:2], 3'b000} +: 8];
          pix_ext  = {14'd0, sel_byte[{~x_q[1:0], 1'b0} +: 2]};
        end
        CLRM_8BPP: begin
          sel_byte = src_word[{x_q[1:0], 3'b000} +: 8];
          pix_ext  = {8'd0, sel_byte};
        end
        CLRM_16BPP: pix_ext = x_q[0] ? src_word[31:16] : src_word[15:0];
        default:    pix_ext = 16'd0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    ready_o     = 1'b0;
    mem_req_o   = 1'b0;
    pix_valid_o = 1'b0;
    load_pix    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (req_i) state_d = S_CALC;
      end
      S_CALC: begin
        if (hit) begin
          load_pix = 1'b1;
          state_d  = S_OUT;
        end else begin
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          load_pix = 1'b1;
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        pix_valid_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, address register and pixel output register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x_q    <= 11'd0;
      y_q    <= 12'd0;
      clrm_q <= 2'd0;
      ximm_q <= 2'd0;
      p1_q   <= 1'b0;
      addr_q <= 19'd0;
      pix_q  <= 16'd0;
    end else begin
      if (accept) begin
        x_q    <= x_i;
        y_q    <= y_i;
        clrm_q <= clrm_i;
        ximm_q <= ximm_i;
        p1_q   <= p1_i;
      end
      if (state_q == S_CALC) addr_q <= calc_addr;
      if (load_pix)          pix_q  <= pix_ext;
    end
  end

  // One-word cache; an invalidate always wins over a fill landing on the same edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      tag_q   <= 19'd0;
      word_q  <= 32'd0;
    end else begin
      if ((state_q == S_FETCH) && mem_ack_i) begin
        word_q <= mem_rdata_i;
        tag_q  <= addr_q;
      end
      if (invalidate_i)                           valid_q <= 1'b0;
      else if ((state_q == S_FETCH) && mem_ack_i) valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_t9990_blit_pixrd.sv
module tb_t9990_blit_pixrd;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [10:0] x;
  logic [11:0] y;
  logic [1:0]  clrm;
  logic [1:0]  ximm;
  logic        p1;
  logic        invalidate;
  logic        ready;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        pix_valid;
  logic [15:0] pix;

  int checks = 0;
  int errors = 0;

  // Reference cache state
  bit          m_valid;
  logic [18:0] m_tag;
  logic [31:0] m_word;

  t9990_blit_pixrd dut (
    .clk_i(clk), .reset_i(rst), .req_i(req), .x_i(x), .y_i(y),
    .clrm_i(clrm), .ximm_i(ximm), .p1_i(p1), .invalidate_i(invalidate),
    .ready_o(ready), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .pix_valid_o(pix_valid), .pix_o(pix)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Byte address of the word holding the pixel, from plain image geometry.
  function automatic logic [18:0] m_addr(input int xx, input int yy, input int cm, input int xi, input bit pp);
    longint bpp, w, b;
    if (pp) begin
      b = ((((xx / 512) % 2) ^ (yy / 2048)) * 262144) + (yy % 2048) * 128 + ((xx % 256) / 8) * 4;
    end else begin
      bpp = 2 << cm;
      w   = 256 << xi;
      b   = yy * (w * bpp / 8) + (xx % w) * bpp / 8;
      b   = b % 524288;
      b   = b - (b % 4);
    end
    return 19'(b);
  endfunction

  // Pixel value: bytes little-endian in the word, sub-byte pixels leftmost-first.
  function automatic logic [15:0] m_pix(input logic [31:0] word, input int xx, input int cm, input int xi, input bit pp);
    longint bpp, w, idx, ppb, sh, wv;
    bpp = pp ? 4 : (2 << cm);
    w   = pp ? 256 : (256 << xi);
    idx = (xx % w) % (32 / bpp);
    if (bpp >= 8) sh = idx * bpp;
    else begin
      ppb = 8 / bpp;
      sh  = (idx / ppb) * 8 + 8 - bpp * ((idx % ppb) + 1);
    end
    wv = longint'(word);
    return 16'((wv >> sh) & ((longint'(1) << bpp) - 1));
  endfunction

  // Drive one request, answer MEM_REQ after dly cycles, observe until PIX_VALID (cycle count from acceptance).
  task automatic run_req(input logic [10:0] tx, input logic [11:0] ty, input logic [1:0] tcm, input logic [1:0] txi,
                         input logic tp1, input int dly, input logic [31:0] rd, input logic inval_ack, input logic spur,
                         output int first_req, output logic [18:0] got_addr, output int lat,
                         output logic [15:0] got_pix, output int ack_cyc);
    bit acked;
    acked = 0; first_req = -1; lat = -1; ack_cyc = -1; got_addr = '0; got_pix = '0;
    @(negedge clk);
    x = tx; y = ty; clrm = tcm; ximm = txi; p1 = tp1; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int cyc = 1; cyc < 60; cyc++) begin
      mem_ack = 1'b0; invalidate = 1'b0; mem_rdata = $urandom;
      if (spur && cyc == 2) begin req = 1'b1; x = tx ^ 11'h155; end
      else req = 1'b0;
      if (mem_req && first_req < 0) begin first_req = cyc; got_addr = mem_addr; end
      if (mem_req && !acked && cyc >= first_req + dly) begin
        mem_ack = 1'b1; mem_rdata = rd; invalidate = inval_ack; acked = 1; ack_cyc = cyc;
      end
      if (pix_valid) begin lat = cyc; got_pix = pix; break; end
      @(negedge clk);
    end
    mem_ack = 1'b0; invalidate = 1'b0; req = 1'b0;
  endtask

  task automatic pulse_inval();
    @(negedge clk); invalidate = 1'b1;
    @(negedge clk); invalidate = 1'b0;
    m_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 0; x = 0; y = 0; clrm = 0; ximm = 0; p1 = 0; invalidate = 0; mem_ack = 0; mem_rdata = 0;
    #23;
    checks++; if (ready !== 1'b1)      begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (mem_req !== 1'b0)    begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (pix_valid !== 1'b0)  begin errors++; $display("FAIL reset_pix_valid got=%b exp=0", pix_valid); end
    checks++; if (mem_addr !== 19'd0)  begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (pix !== 16'd0)       begin errors++; $display("FAIL reset_pix got=%h exp=0", pix); end
    @(negedge clk); rst = 1'b0;
    m_valid = 0; m_tag = 0; m_word = 0;
  endtask

  typedef struct {
    logic [10:0] x; logic [11:0] y; logic [1:0] cm; logic [1:0] xi; logic p1;
    logic [31:0] rd; bit inv_before; bit miss; logic [18:0] addr; logic [15:0] pix;
  } vec_t;

  task automatic test_directed();
    vec_t v[7];
    int fr, lat, ac, dly;
    logic [18:0] ga;
    logic [15:0] gp;
    v[0] = '{11'd5,     12'd3,   2'd2, 2'd1, 1'b0, 32'h11223344, 0, 1, 19'h00604, 16'h0033};
    v[1] = '{11'd6,     12'd3,   2'd2, 2'd1, 1'b0, 32'hDEADBEEF, 0, 0, 19'h00604, 16'h0022};
    v[2] = '{11'd1,     12'd0,   2'd0, 2'd0, 1'b0, 32'h000000E4, 0, 1, 19'h00000, 16'h0002};
    v[3] = '{11'd3,     12'd1,   2'd3, 2'd0, 1'b0, 32'hBEEF1234, 0, 1, 19'h00204, 16'hBEEF};
    v[4] = '{11'h200,   12'd0,   2'd2, 2'd1, 1'b1, 32'h000000A5, 0, 1, 19'h40000, 16'h000A};
    v[5] = '{11'h200,   12'd0,   2'd2, 2'd1, 1'b1, 32'h000000A5, 1, 1, 19'h40000, 16'h000A};
    v[6] = '{11'd1,     12'd256, 2'd1, 2'd3, 1'b0, 32'h0BADF00D, 0, 0, 19'h40000, 16'h0005};
    for (int i = 0; i < 7; i++) begin
      if (v[i].inv_before) pulse_inval();
      dly = $urandom_range(0, 3);
      run_req(v[i].x, v[i].y, v[i].cm, v[i].xi, v[i].p1, dly, v[i].rd, 1'b0, 1'b0, fr, ga, lat, gp, ac);
      if (v[i].miss) begin
        checks++; if (fr !== 2) begin errors++; $display("FAIL dir%0d_memreq_cycle got=%0d exp=2", i, fr); end
        checks++; if (ga !== v[i].addr) begin errors++; $display("FAIL dir%0d_mem_addr got=%h exp=%h", i, ga, v[i].addr); end
        checks++; if (lat !== ac + 1) begin errors++; $display("FAIL dir%0d_miss_latency got=%0d exp=%0d", i, lat, ac + 1); end
      end else begin
        checks++; if (fr !== -1) begin errors++; $display("FAIL dir%0d_unexpected_memreq got=%0d exp=-1", i, fr); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL dir%0d_hit_latency got=%0d exp=2", i, lat); end
        checks++; if (mem_addr !== v[i].addr) begin errors++; $display("FAIL dir%0d_mem_addr got=%h exp=%h", i, mem_addr, v[i].addr); end
      end
      checks++; if (gp !== v[i].pix) begin errors++; $display("FAIL dir%0d_pix got=%h exp=%h", i, gp, v[i].pix); end
      if (v[i].miss) begin m_valid = 1; m_tag = v[i].addr; m_word = v[i].rd; end
      @(negedge clk);
      checks++; if (pix_valid !== 1'b0 || ready !== 1'b1 || pix !== v[i].pix)
        begin errors++; $display("FAIL dir%0d_after_out valid=%b ready=%b pix=%h exp valid=0 ready=1 pix=%h", i, pix_valid, ready, pix, v[i].pix); end
    end
  endtask

  task automatic test_inval_at_ack();
    int fr, lat, ac;
    logic [18:0] ga;
    logic [15:0] gp;
    run_req(11'd0, 12'd0, 2'd2, 2'd0, 1'b0, 1, 32'h00000077, 1'b1, 1'b0, fr, ga, lat, gp, ac);
    checks++; if (fr !== 2 || gp !== 16'h0077) begin errors++; $display("FAIL inval_ack_deliver memreq=%0d pix=%h exp memreq=2 pix=0077", fr, gp); end
    m_valid = 0; m_tag = 19'd0; m_word = 32'h77;
    run_req(11'd0, 12'd0, 2'd2, 2'd0, 1'b0, 0, 32'h00000066, 1'b0, 1'b0, fr, ga, lat, gp, ac);
    checks++; if (fr !== 2 || gp !== 16'h0066) begin errors++; $display("FAIL inval_ack_refetch memreq=%0d pix=%h exp memreq=2 pix=0066", fr, gp); end
    m_valid = 1; m_word = 32'h66;
  endtask

  task automatic test_ignore_busy();
    int fr, lat, ac, bad;
    logic [18:0] ga;
    logic [15:0] gp;
    pulse_inval();
    run_req(11'd9, 12'd7, 2'd1, 2'd2, 1'b0, 3, 32'h13579BDF, 1'b0, 1'b1, fr, ga, lat, gp, ac);
    checks++; if (gp !== m_pix(32'h13579BDF, 9, 1, 2, 0)) begin errors++; $display("FAIL busy_pix got=%h exp=%h", gp, m_pix(32'h13579BDF, 9, 1, 2, 0)); end
    m_valid = 1; m_tag = m_addr(9, 7, 1, 2, 0); m_word = 32'h13579BDF;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready !== 1'b1 || mem_req !== 1'b0 || pix_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL busy_req_queued bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_reset_fetch();
    int fr, lat, ac, seen;
    logic [18:0] ga;
    logic [15:0] gp;
    pulse_inval();
    @(negedge clk); x = 11'd5; y = 12'd3; clrm = 2'd2; ximm = 2'd1; p1 = 1'b0; req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstfetch_memreq_before got=%b exp=1", mem_req); end
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || ready !== 1'b1 || pix_valid !== 1'b0 || mem_addr !== 19'd0 || pix !== 16'd0)
      begin errors++; $display("FAIL rstfetch_immediate memreq=%b ready=%b pv=%b addr=%h pix=%h exp 0 1 0 0 0", mem_req, ready, pix_valid, mem_addr, pix); end
    @(negedge clk); rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55555555;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); mem_ack = 1'b0;
      if (pix_valid !== 1'b0 || mem_req !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstfetch_late_ack bad_cycles=%0d exp=0", seen); end
    m_valid = 0; m_tag = 0; m_word = 0;
    run_req(11'd5, 12'd3, 2'd2, 2'd1, 1'b0, 1, 32'h11223344, 1'b0, 1'b0, fr, ga, lat, gp, ac);
    checks++; if (fr !== 2 || ga !== 19'h00604 || gp !== 16'h0033)
      begin errors++; $display("FAIL rstfetch_rerun memreq=%0d addr=%h pix=%h exp 2 00604 0033", fr, ga, gp); end
    m_valid = 1; m_tag = 19'h00604; m_word = 32'h11223344;
  endtask

  task automatic test_random();
    int fr, lat, ac, dly, cm, xi, xx, yy;
    bit pp, iack, miss;
    logic [18:0] ga, ea;
    logic [15:0] gp, ep;
    logic [31:0] rd;
    int rerr;
    rerr = 0;
    xx = 0; yy = 0; cm = 0; xi = 0; pp = 0;
    for (int n = 0; n < 60; n++) begin
      if (n == 0 || $urandom_range(0, 1) == 0) begin
        pp = ($urandom_range(0, 4) == 0);
        cm = $urandom_range(0, 3); xi = $urandom_range(0, 3);
        xx = $urandom_range(0, 2047); yy = $urandom_range(0, 4095);
      end else begin
        xx = (xx & ~7) | $urandom_range(0, 7);
      end
      if ($urandom_range(0, 5) == 0) pulse_inval();
      iack = ($urandom_range(0, 7) == 0);
      dly  = $urandom_range(0, 4);
      rd   = $urandom;
      ea   = m_addr(xx, yy, cm, xi, pp);
      miss = !(m_valid && m_tag == ea);
      run_req(11'(xx), 12'(yy), 2'(cm), 2'(xi), pp, dly, rd, iack, 1'b0, fr, ga, lat, gp, ac);
      if (miss) begin
        m_word = rd; m_tag = ea; m_valid = !iack;
        checks++; if (fr !== 2 || ga !== ea || lat !== ac + 1) begin
          errors++; rerr++;
          $display("FAIL rnd%0d_miss memreq=%0d addr=%h lat=%0d exp memreq=2 addr=%h lat=%0d", n, fr, ga, lat, ea, ac + 1);
        end
      end else begin
        checks++; if (fr !== -1 || lat !== 2 || mem_addr !== ea) begin
          errors++; rerr++;
          $display("FAIL rnd%0d_hit memreq=%0d lat=%0d addr=%h exp memreq=-1 lat=2 addr=%h", n, fr, lat, mem_addr, ea);
        end
      end
      ep = m_pix(m_word, xx, cm, xi, pp);
      checks++; if (gp !== ep) begin errors++; rerr++; $display("FAIL rnd%0d_pix got=%h exp=%h", n, gp, ep); end
      if (rerr > 10) break;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_inval_at_ack();
    test_ignore_busy();
    test_reset_fetch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/t9990_blit_pixrd.md
T9990_BLIT_PIXRD -- requirements
Module: t9990_blit_pixrd

Interface
REQ-001 CLK  input  1  system clock; all state changes on rising edge.
REQ-002 RESET  input  1  asynchronous, active-high reset.
REQ-003 REQ  input  1  pixel-read request; accepted only when READY=1.
REQ-004 X  input  11  pixel X coordinate.
REQ-005 Y  input  12  pixel Y coordinate.
REQ-006 CLRM  input  2  colour mode (T9990_REG::CLRM_2BPP/4BPP/8BPP/16BPP).
REQ-007 XIMM  input  2  image width (T9990_REG::XIMM_256/512/1024/2048).
REQ-008 P1  input  1  P1 mode; overrides CLRM/XIMM.
REQ-009 INVALIDATE  input  1  VRAM was written; drop cached word.
REQ-010 READY  output  1  high in IDLE only.
REQ-011 MEM_REQ  output  1  VRAM read request, held until MEM_ACK.
REQ-012 MEM_ADDR  output  19  VRAM byte address of 32-bit word, bits[1:0]=0.
REQ-013 MEM_ACK  input  1  read complete; MEM_RDATA valid same cycle.
REQ-014 MEM_RDATA  input  32  read word; byte n = bits[8n+7:8n].
REQ-015 PIX_VALID  output  1  one-cycle pulse, PIX valid.
REQ-016 PIX  output  16  pixel value, zero-extended.

Function
REQ-017 States SHALL be IDLE, CALC, FETCH, OUT.
REQ-018 IDLE: REQ=1 SHALL latch X, Y, CLRM, XIMM, P1 and go to CALC.
REQ-019 CALC: word address SHALL be computed from latched values per the blitter address map: P1 {X[9]^Y[11],Y[10:0],X[7:3],00}; otherwise the word holding 16/8/4/2 pixels (2/4/8/16bpp) of a row XIMM pixels wide, X bits above the width dropped, Y truncated to fill 19 bits, 2bpp/256 prefixed with 0.
REQ-020 CALC: address SHALL be registered into MEM_ADDR; if cache valid and tag equals address -> OUT, else -> FETCH.
REQ-021 FETCH: MEM_REQ=1 and MEM_ADDR stable; on MEM_ACK capture MEM_RDATA into cache word, tag=MEM_ADDR, go to OUT.
REQ-022 OUT: PIX_VALID=1 for exactly one cycle, PIX from cache word, then IDLE.
REQ-023 Latency: REQ accepted in cycle 0 -> hit: PIX_VALID cycle 2; miss: MEM_REQ from cycle 2, MEM_ACK in cycle k -> PIX_VALID cycle k+1.
REQ-024 Extraction 2bpp: byte X[3:2], field bits[7-2*X[1:0] -: 2] of that byte.
REQ-025 Extraction 4bpp and P1: byte X[2:1], X[0]=0 upper nibble, 1 lower nibble.
REQ-026 Extraction 8bpp: byte X[1:0]; 16bpp: X[0]=0 -> bits[15:0], 1 -> bits[31:16].
REQ-027 PIX SHALL hold its value until next OUT.
REQ-028 Cache tag SHALL be address only; mode change alone SHALL NOT invalidate.
REQ-029 INVALIDATE SHALL clear cache valid at next edge in any state; if coincident with MEM_ACK, word is still delivered but valid stays 0.
REQ-030 REQ while READY=0 SHALL be ignored, not queued.

Reset
REQ-031 RESET=1 SHALL force immediately: state IDLE, READY=1, MEM_REQ=0, PIX_VALID=0, MEM_ADDR=0, PIX=0, cache valid=0, tag=0, cache word=0.
REQ-032 Reset during FETCH SHALL abandon the read; a later MEM_ACK in IDLE SHALL be ignored.

Verification
REQ-033 8bpp/512, X=5 Y=3, RDATA=0x11223344 -> MEM_ADDR=0x00604, PIX=0x0033, PIX_VALID after ACK+1.
REQ-034 Then 8bpp/512, X=6 Y=3 -> no MEM_REQ, PIX=0x0022, PIX_VALID 2 cycles after REQ.
REQ-035 2bpp/256, X=1 Y=0, RDATA=0x000000E4 -> MEM_ADDR=0, PIX=0x0002; 16bpp/256 X=3 Y=1, RDATA=0xBEEF1234 -> MEM_ADDR=0x00204, PIX=0xBEEF.
REQ-036 P1, X=0x200 Y=0, RDATA=0x000000A5 -> MEM_ADDR=0x40000, PIX=0x000A; repeat with INVALIDATE between -> second MEM_REQ issued.
REQ-037 RESET pulsed while MEM_REQ=1 -> MEM_REQ=0 same cycle, READY=1, late MEM_ACK produces no PIX_VALID; next identical REQ misses.
